pipeline_scoreboard: RTL

Parametrised hazard/forwarding scoreboard for the pipelined RISC-V core. It replaces the fixed two-source EX/MEM/WB forwarding check and the load-use hazard check. It tracks in-flight destination registers across a configurable number of post-decode stages, each with a per-instruction result-availability stage. From that state it produces a combinational decode stall and registered per-operand forward selects for the instruction entering EX. It sits between the decode stage and the decode-to-execute pipeline latch, and advances on the global pipeline shift enable.

---
 rtl/pipeline_scoreboard_pkg.sv | 24 ++
 rtl/pipeline_scoreboard_match.sv | 41 ++++
 rtl/pipeline_scoreboard.sv | 98 +++++++++
 3 files changed

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
// The entry fields are sized for the widest supported core (8-bit register index, 4-bit availability).
package pipeline_scoreboard_pkg;

    localparam int SB_WSEL_W  = 8;
    localparam int SB_AVAIL_W = 4;

    localparam logic [SB_AVAIL_W-1:0] AVAIL_ALU  = 4'd1;
    localparam logic [SB_AVAIL_W-1:0] AVAIL_LOAD = 4'd2;

    typedef struct packed {
        logic                  valid;
        logic [SB_WSEL_W-1:0]  wsel;
        logic [SB_AVAIL_W-1:0] avail;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_EMPTY = '{valid: 1'b0, wsel: 8'd0, avail: 4'd0};

    // An availability of 0 is meaningless; it behaves like an ALU result.
    function automatic logic [SB_AVAIL_W-1:0] norm_avail(input logic [SB_AVAIL_W-1:0] a);
        return (a == 4'd0) ? AVAIL_ALU : a;
    endfunction

endpackage

// File: rtl/pipeline_scoreboard_match.sv
// Youngest-match finder for one source operand against the forwardable stages.
// The writeback stage is not passed in: it reaches the operand through the register file bypass.
module scoreboard_match
    import pipeline_scoreboard_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int REGBITS = 5,
    parameter int SELW    = $clog2(STAGES)
) (
    input  sb_entry_t          entries [STAGES-1],
    input  logic [REGBITS-1:0] rsel,
    input  logic               used,
    output logic               hit,
    output logic [SELW-1:0]    t,
    output logic               hazard
);

    logic [SB_AVAIL_W-1:0] tgt;
    logic [SB_AVAIL_W-1:0] win_avail;
    logic                  active;

    // Scan oldest to youngest so the lowest-numbered match is the one left standing.
    always_comb begin
        hit       = 1'b0;
        tgt       = 4'd0;
        win_avail = 4'd0;
        active    = used && (rsel != {REGBITS{1'b0}});
        for (int j = STAGES - 2; j >= 0; j--) begin
            if (active && entries[j].valid && (entries[j].wsel == SB_WSEL_W'(rsel))) begin
                hit       = 1'b1;
                tgt       = SB_AVAIL_W'(j + 1);
                win_avail = entries[j].avail;
            end else begin
                hit       = hit;
            end
        end
        t      = SELW'(tgt);
        hazard = hit && (tgt < win_avail);
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding scoreboard between decode and the decode-to-execute latch.
// Tracks in-flight destinations, raises a combinational stall and registers per-operand forward selects.
module pipeline_scoreboard
    import pipeline_scoreboard_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int NSRC    = 2,
    parameter int REGBITS = 5,
    parameter int SELW    = $clog2(STAGES)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        advance,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic                        id_reg_write,
    input  logic [REGBITS-1:0]          id_wsel,
    input  logic [NSRC*REGBITS-1:0]     id_rsel,
    input  logic [NSRC-1:0]             id_rsel_used,
    input  logic [SELW-1:0]             id_avail,
    output logic                        stall,
    output logic [NSRC*SELW-1:0]        fwd_sel,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCCW = $clog2(STAGES + 1);

    sb_entry_t              ent_r    [STAGES];
    sb_entry_t              cmp_ents [STAGES-1];
    sb_entry_t              dec_ent_s;
    logic [NSRC-1:0]        hit_s;
    logic [NSRC-1:0]        hazard_s;
    logic [NSRC*SELW-1:0]   tgt_s;
    logic [NSRC*SELW-1:0]   fwd_next_s;
    logic [OCCW-1:0]        occ_next_s;
    logic                   bubble_s;

    // Only the stages that can still forward take part in matching.
    always_comb begin
        for (int k = 0; k < STAGES - 1; k++) begin
            cmp_ents[k] = ent_r[k];
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_match
        scoreboard_match #(
            .STAGES  (STAGES),
            .REGBITS (REGBITS),
            .SELW    (SELW)
        ) u_match (
            .entries (cmp_ents),
            .rsel    (id_rsel[i*REGBITS +: REGBITS]),
            .used    (id_rsel_used[i]),
            .hit     (hit_s[i]),
            .t       (tgt_s[i*SELW +: SELW]),
            .hazard  (hazard_s[i])
        );
    end

    // Flush overrides stall; any non-issuing cycle becomes a bubble in EX.
    always_comb begin
        stall           = id_valid & ~flush & (|hazard_s);
        bubble_s        = stall | flush | ~id_valid;
        dec_ent_s.valid = ~bubble_s & id_reg_write & (id_wsel != {REGBITS{1'b0}});
        dec_ent_s.wsel  = SB_WSEL_W'(id_wsel);
        dec_ent_s.avail = norm_avail(SB_AVAIL_W'(id_avail));
        for (int i = 0; i < NSRC; i++) begin
            if (bubble_s || !hit_s[i]) begin
                fwd_next_s[i*SELW +: SELW] = {SELW{1'b0}};
            end else begin
                fwd_next_s[i*SELW +: SELW] = tgt_s[i*SELW +: SELW];
            end
        end
        occ_next_s = {{(OCCW-1){1'b0}}, dec_ent_s.valid};
        for (int k = 0; k < STAGES - 1; k++) begin
            occ_next_s = occ_next_s + {{(OCCW-1){1'b0}}, ent_r[k].valid};
        end
    end

    // Entry shift register and registered outputs; everything freezes while advance is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                ent_r[k] <= SB_ENTRY_EMPTY;
            end
            fwd_sel   <= {(NSRC*SELW){1'b0}};
            occupancy <= {OCCW{1'b0}};
        end else if (advance) begin
            ent_r[0] <= dec_ent_s;
            for (int k = 1; k < STAGES; k++) begin
                ent_r[k] <= ent_r[k-1];
            end
            fwd_sel   <= fwd_next_s;
            occupancy <= occ_next_s;
        end
    end

endmodule
